// File: rtl/vending_pkg.sv
// ---------------------------------------------------------------------------
// vending_pkg
// Definitions shared by the coin collector front end and the vending core:
//   - service state codes reported by the core (OFF/ON/BUSY)
//   - coin type codes and their NTD values
//   - item codes and item costs
//   - the collector state enum and the per-denomination count bundle
//   - credit_of(): weighted credit sum of a count bundle
// ---------------------------------------------------------------------------
package vending_pkg;

    // Core service state, as seen on service_type_in
    localparam logic [1:0] SVC_OFF  = 2'b00;
    localparam logic [1:0] SVC_ON   = 2'b01;
    localparam logic [1:0] SVC_BUSY = 2'b10;

    // Coin type codes
    localparam logic [1:0] COIN_NTD50 = 2'b00;
    localparam logic [1:0] COIN_NTD10 = 2'b01;
    localparam logic [1:0] COIN_NTD5  = 2'b10;
    localparam logic [1:0] COIN_NTD1  = 2'b11;

    // Coin values in NTD
    localparam logic [7:0] VAL_NTD50 = 8'd50;
    localparam logic [7:0] VAL_NTD10 = 8'd10;
    localparam logic [7:0] VAL_NTD5  = 8'd5;
    localparam logic [7:0] VAL_NTD1  = 8'd1;

    // Item codes
    localparam logic [1:0] ITEM_NONE = 2'b00;
    localparam logic [1:0] ITEM_A    = 2'b01;
    localparam logic [1:0] ITEM_B    = 2'b10;
    localparam logic [1:0] ITEM_C    = 2'b11;

    // Item costs in NTD (evaluated by the core)
    localparam logic [7:0] COST_A = 8'd8;
    localparam logic [7:0] COST_B = 8'd15;
    localparam logic [7:0] COST_C = 8'd22;

    // Saturation limit per denomination: the core's coin inputs are 2 bits
    localparam logic [1:0] MAX_PER_COIN = 2'd3;

    // Collector FSM states
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_COLLECT   = 3'd1,
        ST_ISSUE     = 3'd2,
        ST_WAIT_BUSY = 3'd3,
        ST_WAIT_DONE = 3'd4
    } collector_state_t;

    // Held coin counts, one 2-bit count per denomination
    typedef struct packed {
        logic [1:0] n50;
        logic [1:0] n10;
        logic [1:0] n5;
        logic [1:0] n1;
    } coin_counts_t;

    // Weighted credit of a count bundle; counts are zero-extended to 8 bits
    // before weighting. Maximum 3*(50+10+5+1) = 198 fits in 8 bits.
    function automatic logic [7:0] credit_of(input coin_counts_t c);
        logic [7:0] sum_v;
        sum_v = ({6'd0, c.n50} * VAL_NTD50)
              + ({6'd0, c.n10} * VAL_NTD10)
              + ({6'd0, c.n5}  * VAL_NTD5)
              + ({6'd0, c.n1}  * VAL_NTD1);
        return sum_v;
    endfunction

endpackage

// File: rtl/coin_bank.sv
// ---------------------------------------------------------------------------
// coin_bank
// Four saturating 2-bit coin counters plus the registered credit adder.
// Ports:
//   clk, reset     clock, asynchronous active-high reset
//   inc            count the coin selected by coin_type (already accepted)
//   coin_type      denomination of the incoming coin
//   clear          zero all counters (refund or issue)
//   credit_en      credit_value follows the counts; 0 otherwise
//   counts         current held counts
//   saturated      the denomination selected by coin_type is full
//   credit_value   registered weighted credit of the counts
// ---------------------------------------------------------------------------
module coin_bank
    import vending_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic [1:0]   coin_type,
    input  logic         clear,
    input  logic         credit_en,
    output coin_counts_t counts,
    output logic         saturated,
    output logic [7:0]   credit_value
);

    coin_counts_t counts_r;
    logic [7:0]   credit_r;

    // Saturating increment of one 2-bit count
    function automatic logic [1:0] sat_inc(input logic [1:0] n);
        logic [1:0] r_v;
        if (n == MAX_PER_COIN) begin
            r_v = n;
        end else begin
            r_v = n + 2'd1;
        end
        return r_v;
    endfunction

    // Per-denomination counters: clear wins over increment
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            counts_r <= '0;
        end else if (clear) begin
            counts_r <= '0;
        end else if (inc) begin
            case (coin_type)
                COIN_NTD50: counts_r.n50 <= sat_inc(counts_r.n50);
                COIN_NTD10: counts_r.n10 <= sat_inc(counts_r.n10);
                COIN_NTD5:  counts_r.n5  <= sat_inc(counts_r.n5);
                COIN_NTD1:  counts_r.n1  <= sat_inc(counts_r.n1);
                default:    counts_r     <= counts_r;
            endcase
        end else begin
            counts_r <= counts_r;
        end
    end

    // Saturation flag for the denomination currently on coin_type
    always_comb begin
        saturated = 1'b0;
        case (coin_type)
            COIN_NTD50: saturated = (counts_r.n50 == MAX_PER_COIN);
            COIN_NTD10: saturated = (counts_r.n10 == MAX_PER_COIN);
            COIN_NTD5:  saturated = (counts_r.n5  == MAX_PER_COIN);
            COIN_NTD1:  saturated = (counts_r.n1  == MAX_PER_COIN);
            default:    saturated = 1'b0;
        endcase
    end

    // Credit register: lags the counts by one cycle, forced to 0 when disabled
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            credit_r <= 8'd0;
        end else if (credit_en) begin
            credit_r <= credit_of(counts_r);
        end else begin
            credit_r <= 8'd0;
        end
    end

    assign counts       = counts_r;
    assign credit_value = credit_r;

endmodule

// File: rtl/coin_collector.sv
// ---------------------------------------------------------------------------
// coin_collector
// Front end of the vending machine core. Collects coins, takes one item
// selection, presents a single-cycle purchase request to the core and waits
// for the core to finish. Cancel and inactivity timeout are refunded here,
// so the core never sees an abandoned transaction.
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   coin_valid, coin_type      one coin inserted this cycle and its type
//   item_req_valid/_type       item button and selected item
//   cancel                     refund request
//   service_type_in            core service state (OFF/ON/BUSY)
//   coin_in_ntd_*              counts presented to the core (issue cycle only)
//   item_type_out              item presented to the core (issue cycle only)
//   coin_reject                pulse: last cycle's coin was returned
//   refund_valid, refund_ntd_* refund pulse and refunded counts
//   credit_value               weighted credit (COLLECT/ISSUE only)
//   busy                       transaction handed to / owned by the core
// Parameter:
//   TIMEOUT_CYCLES             idle COLLECT cycles before auto refund (1..255)
// ---------------------------------------------------------------------------
module coin_collector
    import vending_pkg::*;
#(
    parameter logic [7:0] TIMEOUT_CYCLES = 8'd255
)
(
    input  logic       clk,
    input  logic       reset,
    input  logic       coin_valid,
    input  logic [1:0] coin_type,
    input  logic       item_req_valid,
    input  logic [1:0] item_req_type,
    input  logic       cancel,
    input  logic [1:0] service_type_in,
    output logic [1:0] coin_in_ntd_50,
    output logic [1:0] coin_in_ntd_10,
    output logic [1:0] coin_in_ntd_5,
    output logic [1:0] coin_in_ntd_1,
    output logic [1:0] item_type_out,
    output logic       coin_reject,
    output logic       refund_valid,
    output logic [1:0] refund_ntd_50,
    output logic [1:0] refund_ntd_10,
    output logic [1:0] refund_ntd_5,
    output logic [1:0] refund_ntd_1,
    output logic [7:0] credit_value,
    output logic       busy
);

    collector_state_t state_r, state_s;
    logic [7:0]   timer_r, timer_s;
    logic [1:0]   item_r;
    coin_counts_t counts_s;
    logic         saturated_s;
    logic         accept_s, clear_s, refund_s, issue_s, latch_item_s;
    logic         credit_en_s, busy_s;

    coin_counts_t coin_in_r, refund_r;
    logic [1:0]   item_out_r;
    logic         reject_r, refund_valid_r, busy_r;

    coin_bank u_bank (
        .clk          (clk),
        .reset        (reset),
        .inc          (accept_s),
        .coin_type    (coin_type),
        .clear        (clear_s),
        .credit_en    (credit_en_s),
        .counts       (counts_s),
        .saturated    (saturated_s),
        .credit_value (credit_value)
    );

    // State, inactivity timer and latched item
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
            timer_r <= 8'd0;
            item_r  <= ITEM_NONE;
        end else begin
            state_r <= state_s;
            timer_r <= timer_s;
            if (latch_item_s) begin
                item_r <= item_req_type;
            end else if (issue_s) begin
                item_r <= ITEM_NONE;
            end else begin
                item_r <= item_r;
            end
        end
    end

    // Next state and per-cycle decisions; COLLECT resolves cancel, timeout,
    // item request and coin strictly in that priority order
    always_comb begin
        state_s      = state_r;
        timer_s      = 8'd0;
        accept_s     = 1'b0;
        clear_s      = 1'b0;
        refund_s     = 1'b0;
        issue_s      = 1'b0;
        latch_item_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (coin_valid && !saturated_s) begin
                    accept_s = 1'b1;
                    state_s  = ST_COLLECT;
                end else begin
                    state_s  = ST_IDLE;
                end
            end
            ST_COLLECT: begin
                timer_s = timer_r + 8'd1;
                if (cancel) begin
                    refund_s = 1'b1;
                    clear_s  = 1'b1;
                    state_s  = ST_IDLE;
                end else if (timer_r == (TIMEOUT_CYCLES - 8'd1)) begin
                    // this idle cycle brings the timer to TIMEOUT_CYCLES
                    refund_s = 1'b1;
                    clear_s  = 1'b1;
                    state_s  = ST_IDLE;
                end else if (item_req_valid && (item_req_type != ITEM_NONE)) begin
                    latch_item_s = 1'b1;
                    state_s      = ST_ISSUE;
                end else if (coin_valid && !saturated_s) begin
                    accept_s = 1'b1;
                    timer_s  = 8'd0;
                end else begin
                    state_s  = ST_COLLECT;
                end
            end
            ST_ISSUE: begin
                if (service_type_in == SVC_ON) begin
                    issue_s = 1'b1;
                    clear_s = 1'b1;
                    state_s = ST_WAIT_BUSY;
                end else begin
                    state_s = ST_ISSUE;
                end
            end
            ST_WAIT_BUSY: begin
                if (service_type_in == SVC_BUSY) begin
                    state_s = ST_WAIT_DONE;
                end else begin
                    state_s = ST_WAIT_BUSY;
                end
            end
            ST_WAIT_DONE: begin
                if (service_type_in == SVC_OFF) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_WAIT_DONE;
                end
            end
            default: begin
                clear_s = 1'b1;
                state_s = ST_IDLE;
            end
        endcase
    end

    // Output qualifiers derived from current / next state
    always_comb begin
        credit_en_s = (state_r == ST_COLLECT) || (state_r == ST_ISSUE);
        busy_s      = (state_s == ST_ISSUE) || (state_s == ST_WAIT_BUSY)
                   || (state_s == ST_WAIT_DONE);
    end

    // Registered outputs: request, refund and reject are single-cycle pulses
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            coin_in_r      <= '0;
            item_out_r     <= ITEM_NONE;
            reject_r       <= 1'b0;
            refund_valid_r <= 1'b0;
            refund_r       <= '0;
            busy_r         <= 1'b0;
        end else begin
            coin_in_r      <= issue_s  ? counts_s : '0;
            item_out_r     <= issue_s  ? item_r   : ITEM_NONE;
            reject_r       <= coin_valid && !accept_s;
            refund_valid_r <= refund_s;
            refund_r       <= refund_s ? counts_s : '0;
            busy_r         <= busy_s;
        end
    end

    assign coin_in_ntd_50 = coin_in_r.n50;
    assign coin_in_ntd_10 = coin_in_r.n10;
    assign coin_in_ntd_5  = coin_in_r.n5;
    assign coin_in_ntd_1  = coin_in_r.n1;
    assign item_type_out  = item_out_r;
    assign coin_reject    = reject_r;
    assign refund_valid   = refund_valid_r;
    assign refund_ntd_50  = refund_r.n50;
    assign refund_ntd_10  = refund_r.n10;
    assign refund_ntd_5   = refund_r.n5;
    assign refund_ntd_1   = refund_r.n1;
    assign busy           = busy_r;

endmodule
